// File: rtl/stream_fifo_packet_writer_pkg.sv
// rtl/stream_fifo_packet_writer_pkg.sv - shared w_ctrl codes, FSM states and header size for the packet writer
package stream_fifo_packet_writer_pkg;

    localparam logic [2:0] CTRL_NOP               = 3'd0;
    localparam logic [2:0] CTRL_WRITE             = 3'd1;
    localparam logic [2:0] CTRL_EOF_WITH_WRITE    = 3'd2;
    localparam logic [2:0] CTRL_EOF_WITHOUT_WRITE = 3'd3;
    localparam logic [2:0] CTRL_HEAD              = 3'd4;
    localparam logic [2:0] CTRL_FINAL_HEAD        = 3'd5;
    localparam logic [2:0] CTRL_DISCARD           = 3'd6;

    // Header slots the controller reserves on the first WRITE of each packet.
    localparam int HDR_WORDS = 2;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_DATA = 3'd1,
        ST_HDR  = 3'd2,
        ST_FIN  = 3'd3,
        ST_DROP = 3'd4
    } wr_state_e;

endpackage

// File: rtl/stream_fifo_packet_writer_if.sv
// rtl/stream_fifo_packet_writer_if.sv - byte source and controller write-port bundle for the packet writer
interface stream_fifo_packet_writer_if #(
    parameter int ADDRWIDTH = 4
);
    logic                 s_valid;
    logic                 s_ready;
    logic [7:0]           s_data;
    logic                 s_last;
    logic                 s_abort;
    logic                 s_eof;
    logic                 w_full;
    logic [ADDRWIDTH:0]   w_counter;
    logic [2:0]           w_ctrl;
    logic [7:0]           w_data;
    logic                 pkt_drop;

    modport master (
        output s_valid, s_data, s_last, s_abort, s_eof, w_full, w_counter,
        input  s_ready, w_ctrl, w_data, pkt_drop
    );

    modport slave (
        input  s_valid, s_data, s_last, s_abort, s_eof, w_full, w_counter,
        output s_ready, w_ctrl, w_data, pkt_drop
    );

endinterface

// File: rtl/stream_fifo_packet_writer.sv
// rtl/stream_fifo_packet_writer.sv - byte stream to w_ctrl packetiser with back-filled 2-byte length header
// Optional zero-length packets via s_eof when PKT_WRITER_ZLP_EN is defined.
module stream_fifo_packet_writer
    import stream_fifo_packet_writer_pkg::*;
#(
    parameter int ADDRWIDTH = 4,
    parameter int MAX_LEN   = (1 << ADDRWIDTH) - 2
) (
    input  logic                         w_clk,
    input  logic                         rst_n,
    stream_fifo_packet_writer_if.slave   bus
);

    localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);

    wr_state_e   state;
    logic [15:0] len;
    logic        out_en;
    logic        accept;

    // out_en holds s_ready low for the first cycle after reset so the
    // controller, reset by the same rst_n, settles before any byte lands.
    always_comb begin
        bus.s_ready = 1'b0;
        if (out_en) begin
            if (state == ST_DROP)
                bus.s_ready = 1'b1;
            else if ((state == ST_IDLE) || (state == ST_DATA))
                bus.s_ready = !bus.w_full;
        end
    end

    assign accept = bus.s_valid && bus.s_ready;

    logic unused_inputs;
    assign unused_inputs = ^{bus.w_counter, bus.s_eof};

    always_ff @(posedge w_clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            len          <= 16'd0;
            out_en       <= 1'b0;
            bus.w_ctrl   <= CTRL_NOP;
            bus.w_data   <= 8'd0;
            bus.pkt_drop <= 1'b0;
        end else begin
            out_en       <= 1'b1;
            bus.w_ctrl   <= CTRL_NOP;
            bus.w_data   <= 8'd0;
            bus.pkt_drop <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        len        <= 16'd1;
                        bus.w_data <= bus.s_data;
                        if (bus.s_last) begin
                            bus.w_ctrl <= CTRL_EOF_WITH_WRITE;
                            state      <= ST_HDR;
                        end else begin
                            bus.w_ctrl <= CTRL_WRITE;
                            state      <= ST_DATA;
                        end
                    end
`ifdef PKT_WRITER_ZLP_EN
                    else if (bus.s_eof && !bus.s_valid) begin
                        bus.w_ctrl <= CTRL_EOF_WITHOUT_WRITE;
                        len        <= 16'd0;
                        state      <= ST_HDR;
                    end
`endif
                end
                ST_DATA: begin
                    if (bus.s_abort) begin
                        bus.w_ctrl   <= CTRL_DISCARD;
                        bus.pkt_drop <= 1'b1;
                        len          <= 16'd0;
                        state        <= ST_IDLE;
                    end else if (accept) begin
                        // Checked before incrementing so len can never exceed MAX_LEN.
                        if (len >= MAX_LEN_W) begin
                            bus.w_ctrl   <= CTRL_DISCARD;
                            bus.pkt_drop <= 1'b1;
                            len          <= 16'd0;
                            state        <= bus.s_last ? ST_IDLE : ST_DROP;
                        end else begin
                            len        <= len + 16'd1;
                            bus.w_data <= bus.s_data;
                            if (bus.s_last) begin
                                bus.w_ctrl <= CTRL_EOF_WITH_WRITE;
                                state      <= ST_HDR;
                            end else begin
                                bus.w_ctrl <= CTRL_WRITE;
                            end
                        end
                    end
`ifdef PKT_WRITER_ZLP_EN
                    else if (bus.s_eof && !bus.s_valid) begin
                        bus.w_ctrl <= CTRL_EOF_WITHOUT_WRITE;
                        state      <= ST_HDR;
                    end
`endif
                end
                ST_HDR: begin
                    // Header slots were reserved up front, so w_full does not stall here.
                    if (bus.s_abort) begin
                        bus.w_ctrl   <= CTRL_DISCARD;
                        bus.pkt_drop <= 1'b1;
                        len          <= 16'd0;
                        state        <= ST_IDLE;
                    end else begin
                        bus.w_ctrl <= CTRL_HEAD;
                        bus.w_data <= len[15:8];
                        state      <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    bus.w_ctrl <= CTRL_FINAL_HEAD;
                    bus.w_data <= len[7:0];
                    len        <= 16'd0;
                    state      <= ST_IDLE;
                end
                ST_DROP: begin
                    if (accept && bus.s_last)
                        state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    len   <= 16'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stream_fifo_packet_writer.sv
// tb/tb_stream_fifo_packet_writer.sv - randomized self-checking bench for stream_fifo_packet_writer
module tb_stream_fifo_packet_writer;

    localparam int AW      = 4;
    localparam int MAXL    = (1 << AW) - 2;
    localparam logic [2:0] C_WRITE = 3'd1;
    localparam logic [2:0] C_EOFW  = 3'd2;
    localparam logic [2:0] C_EOFNW = 3'd3;
    localparam logic [2:0] C_HEAD  = 3'd4;
    localparam logic [2:0] C_FINAL = 3'd5;
    localparam logic [2:0] C_DISC  = 3'd6;

    typedef struct packed {
        logic [2:0] c;
        logic [7:0] d;
        logic       p;
    } ev_t;

    logic w_clk = 1'b0;
    logic rst_n = 1'b0;
    int   compared = 0;
    int   mismatched = 0;
    ev_t  obs[$];
    ev_t  exp_q[$];
    logic [7:0] pkt [0:31];

    stream_fifo_packet_writer_if #(.ADDRWIDTH(AW)) bus ();

    stream_fifo_packet_writer #(.ADDRWIDTH(AW)) dut (
        .w_clk (w_clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 w_clk = ~w_clk;

    always @(negedge w_clk)
        if (rst_n && (bus.w_ctrl !== 3'd0 || bus.pkt_drop !== 1'b0))
            obs.push_back('{c: bus.w_ctrl, d: bus.w_data, p: bus.pkt_drop});

    task automatic idle_inputs();
        bus.s_valid = 1'b0; bus.s_data = 8'd0; bus.s_last = 1'b0;
        bus.s_abort = 1'b0; bus.s_eof = 1'b0; bus.w_full = 1'b0;
    endtask

    task automatic fill_pkt(input int n);
        for (int k = 0; k < n; k++) pkt[k] = 8'($urandom);
    endtask

    // Expected command stream for one packet, from the packet-level rules.
    task automatic model_packet(input int n, input int abort_after);
        if (abort_after > 0) begin
            for (int k = 0; k < abort_after; k++) exp_q.push_back('{c: C_WRITE, d: pkt[k], p: 1'b0});
            exp_q.push_back('{c: C_DISC, d: 8'h00, p: 1'b1});
        end else if (n > MAXL) begin
            for (int k = 0; k < MAXL; k++) exp_q.push_back('{c: C_WRITE, d: pkt[k], p: 1'b0});
            exp_q.push_back('{c: C_DISC, d: 8'h00, p: 1'b1});
        end else begin
            for (int k = 0; k < n - 1; k++) exp_q.push_back('{c: C_WRITE, d: pkt[k], p: 1'b0});
            exp_q.push_back('{c: C_EOFW, d: pkt[n-1], p: 1'b0});
            exp_q.push_back('{c: C_HEAD, d: 8'((n >> 8) & 255), p: 1'b0});
            exp_q.push_back('{c: C_FINAL, d: 8'(n & 255), p: 1'b0});
        end
    endtask

    task automatic send_packet(input int n, input int abort_after, input int full_pct);
        int  i = 0;
        int  guard = 0;
        bit  done = 1'b0;
        bit  abort_cyc;
        while (!done) begin
            @(posedge w_clk); #1;
            bus.w_full    = ($urandom_range(0, 99) < full_pct);
            bus.w_counter = 5'($urandom);
            abort_cyc     = (abort_after > 0) && (i == abort_after);
            bus.s_abort   = abort_cyc;
            bus.s_valid   = abort_cyc ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.s_data    = pkt[i];
            bus.s_last    = !abort_cyc && (i == n - 1);
            @(negedge w_clk);
            if (abort_cyc) done = 1'b1;
            else if (bus.s_valid && bus.s_ready) begin
                i++;
                if (i == n) done = 1'b1;
            end
            guard++;
            if (!done && guard > 500) begin
                compared++; mismatched++;
                $display("FAIL send_timeout accepted %0d of %0d bytes", i, n);
                done = 1'b1;
            end
        end
        @(posedge w_clk); #1;
        idle_inputs();
        repeat (2) begin
            bus.w_full = 1'($urandom_range(0, 1));
            @(posedge w_clk); #1;
        end
        bus.w_full = 1'b0;
        model_packet(n, abort_after);
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.w_counter = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge w_clk);
        @(negedge w_clk);
        compared++;
        if ({bus.w_ctrl, bus.w_data, bus.pkt_drop, bus.s_ready} !== 13'd0) begin
            mismatched++;
            $display("FAIL reset_outputs got ctrl=%0d data=%02h drop=%0b ready=%0b required all 0",
                     bus.w_ctrl, bus.w_data, bus.pkt_drop, bus.s_ready);
        end
        @(posedge w_clk); #1; rst_n = 1'b1;
        @(posedge w_clk); #1;
        @(negedge w_clk);
        compared++;
        if (bus.s_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_ready_after got %0b required 1", bus.s_ready);
        end
    endtask

    task automatic test_basic();
        logic [2:0] ec [0:6] = '{3'd1, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd0};
        logic [7:0] ed [0:6] = '{8'h10, 8'h11, 8'h12, 8'h00, 8'h03, 8'h00, 8'h00};
        for (int c = 0; c < 8; c++) begin
            @(posedge w_clk); #1;
            bus.s_valid = (c < 3);
            bus.s_data  = (c < 3) ? 8'(8'h10 + c) : 8'h00;
            bus.s_last  = (c == 2);
            @(negedge w_clk);
            if (c < 3) begin
                compared++;
                if (bus.s_ready !== 1'b1) begin
                    mismatched++;
                    $display("FAIL basic_ready cycle %0d got %0b required 1", c, bus.s_ready);
                end
            end
            if (c >= 1) begin
                compared++;
                if (bus.w_ctrl !== ec[c-1] || bus.w_data !== ed[c-1]) begin
                    mismatched++;
                    $display("FAIL basic_cmd cycle %0d got %0d/%02h required %0d/%02h",
                             c, bus.w_ctrl, bus.w_data, ec[c-1], ed[c-1]);
                end
            end
        end
        idle_inputs();
    endtask

    task automatic test_backpressure();
        int idx = 0;
        obs.delete(); exp_q.delete();
        pkt[0] = 8'h10; pkt[1] = 8'h11; pkt[2] = 8'h12;
        for (int c = 0; c < 14; c++) begin
            @(posedge w_clk); #1;
            bus.w_full  = (c >= 1 && c <= 4);
            bus.s_valid = (idx < 3);
            bus.s_data  = (idx < 3) ? pkt[idx] : 8'h00;
            bus.s_last  = (idx == 2);
            @(negedge w_clk);
            if (c >= 1 && c <= 4) begin
                compared++;
                if (bus.s_ready !== 1'b0) begin
                    mismatched++;
                    $display("FAIL bp_ready cycle %0d got %0b required 0", c, bus.s_ready);
                end
            end
            if (c >= 2 && c <= 5) begin
                compared++;
                if (bus.w_ctrl !== 3'd0) begin
                    mismatched++;
                    $display("FAIL bp_nop cycle %0d got %0d required 0", c, bus.w_ctrl);
                end
            end
            if (bus.s_valid && bus.s_ready) idx++;
        end
        idle_inputs();
        model_packet(3, 0);
        @(posedge w_clk); #1;
        compared++;
        if (obs.size() != exp_q.size()) begin
            mismatched++;
            $display("FAIL bp_count got %0d required %0d", obs.size(), exp_q.size());
        end
        for (int k = 0; k < obs.size() && k < exp_q.size(); k++) begin
            compared++;
            if (obs[k] !== exp_q[k]) begin
                mismatched++;
                $display("FAIL bp_cmd[%0d] got %03h required %03h", k, obs[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_overflow();
        obs.delete(); exp_q.delete();
        fill_pkt(MAXL + 1);
        send_packet(MAXL + 1, 0, 0);
        fill_pkt(MAXL + 4);
        send_packet(MAXL + 4, 0, 20);
        fill_pkt(2);
        send_packet(2, 0, 0);
        repeat (4) @(posedge w_clk); #1;
        compared++;
        if (obs.size() != exp_q.size()) begin
            mismatched++;
            $display("FAIL ovf_count got %0d required %0d", obs.size(), exp_q.size());
        end
        for (int k = 0; k < obs.size() && k < exp_q.size(); k++) begin
            compared++;
            if (obs[k] !== exp_q[k]) begin
                mismatched++;
                $display("FAIL ovf_cmd[%0d] got %03h required %03h", k, obs[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_abort();
        obs.delete(); exp_q.delete();
        fill_pkt(3);
        send_packet(3, 2, 0);
        pkt[0] = 8'hAA;
        send_packet(1, 0, 0);
        repeat (4) @(posedge w_clk); #1;
        compared++;
        if (obs.size() != exp_q.size()) begin
            mismatched++;
            $display("FAIL abort_count got %0d required %0d", obs.size(), exp_q.size());
        end
        for (int k = 0; k < obs.size() && k < exp_q.size(); k++) begin
            compared++;
            if (obs[k] !== exp_q[k]) begin
                mismatched++;
                $display("FAIL abort_cmd[%0d] got %03h required %03h", k, obs[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_reset_in_hdr();
        @(posedge w_clk); #1;
        bus.s_valid = 1'b1; bus.s_data = 8'h55; bus.s_last = 1'b1;
        @(posedge w_clk); #1;
        idle_inputs();
        rst_n = 1'b0;
        @(posedge w_clk); #1;
        rst_n = 1'b1;
        @(negedge w_clk);
        compared++;
        if (bus.w_ctrl !== 3'd0 || bus.s_ready !== 1'b0 || bus.pkt_drop !== 1'b0) begin
            mismatched++;
            $display("FAIL rst_hdr got ctrl=%0d ready=%0b drop=%0b required 0/0/0",
                     bus.w_ctrl, bus.s_ready, bus.pkt_drop);
        end
        @(posedge w_clk); #1;
        @(negedge w_clk);
        compared++;
        if (bus.s_ready !== 1'b1 || bus.w_ctrl !== 3'd0) begin
            mismatched++;
            $display("FAIL rst_hdr_idle got ready=%0b ctrl=%0d required 1/0", bus.s_ready, bus.w_ctrl);
        end
        obs.delete(); exp_q.delete();
        fill_pkt(1);
        send_packet(1, 0, 0);
        repeat (4) @(posedge w_clk); #1;
        compared++;
        if (obs.size() != exp_q.size()) begin
            mismatched++;
            $display("FAIL rst_pkt_count got %0d required %0d", obs.size(), exp_q.size());
        end
        for (int k = 0; k < obs.size() && k < exp_q.size(); k++) begin
            compared++;
            if (obs[k] !== exp_q[k]) begin
                mismatched++;
                $display("FAIL rst_pkt_cmd[%0d] got %03h required %03h", k, obs[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_eof();
        obs.delete(); exp_q.delete();
        @(posedge w_clk); #1;
        bus.s_eof = 1'b1;
        @(posedge w_clk); #1;
        bus.s_eof = 1'b0;
        repeat (5) @(posedge w_clk); #1;
`ifdef PKT_WRITER_ZLP_EN
        exp_q.push_back('{c: C_EOFNW, d: 8'h00, p: 1'b0});
        exp_q.push_back('{c: C_HEAD,  d: 8'h00, p: 1'b0});
        exp_q.push_back('{c: C_FINAL, d: 8'h00, p: 1'b0});
`endif
        compared++;
        if (obs.size() != exp_q.size()) begin
            mismatched++;
            $display("FAIL eof_count got %0d required %0d", obs.size(), exp_q.size());
        end
        for (int k = 0; k < obs.size() && k < exp_q.size(); k++) begin
            compared++;
            if (obs[k] !== exp_q[k]) begin
                mismatched++;
                $display("FAIL eof_cmd[%0d] got %03h required %03h", k, obs[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_random();
        int n;
        int ab;
        obs.delete(); exp_q.delete();
        for (int p = 0; p < 30; p++) begin
            n  = int'($urandom_range(1, 20));
            ab = 0;
            if (n > 1 && $urandom_range(0, 4) == 0)
                ab = int'($urandom_range(1, (n - 1 < MAXL) ? n - 1 : MAXL));
            fill_pkt(n);
            send_packet(n, ab, 30);
        end
        repeat (4) @(posedge w_clk); #1;
        compared++;
        if (obs.size() != exp_q.size()) begin
            mismatched++;
            $display("FAIL rand_count got %0d required %0d", obs.size(), exp_q.size());
        end
        for (int k = 0; k < obs.size() && k < exp_q.size(); k++) begin
            compared++;
            if (obs[k] !== exp_q[k]) begin
                mismatched++;
                $display("FAIL rand_cmd[%0d] got %03h required %03h", k, obs[k], exp_q[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_overflow();
        test_abort();
        test_reset_in_hdr();
        test_eof();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
